// File: rtl/axi_mem_read_responder.sv
// axi_mem_read_responder
//   AXI4 read-channel slave serving INCR bursts from a single-port synchronous
//   RAM (read data one cycle after memRdEn). AR requests are queued in a small
//   FIFO, the burst engine turns each into one RAM read per beat, and beats
//   return through a two-entry skid buffer so R streams at one beat per cycle
//   under arbitrary axiRReady backpressure.
// Ports:
//   clk, axiReset      - clock; asynchronous active-high reset
//   axiAR*             - read address channel (axiARCache ignored)
//   axiR*              - read data channel
//   memRdEn/Addr/Data  - RAM read port
// Optional feature (macro AXI_READ_RESP_ERR_CHECK_EN):
//   defined   - nonzero address bits above the RAM give DECERR, a beat size
//               other than DataIndexSize gives SLVERR (DECERR wins); error
//               bursts return len+1 zero-data beats without touching the RAM.
//   undefined - always OKAY, address taken modulo RAM size, size ignored.
module axi_mem_read_responder #(
  parameter int DataIndexSize   = 4,
  parameter int AxiIdWidth      = 4,
  parameter int MemAddrWidth    = 12,
  parameter int ArFifoIndexSize = 2,
  localparam int DataWidth      = (1 << DataIndexSize) * 8
) (
  input  logic                    clk,
  input  logic                    axiReset,
  input  logic                    axiARValid,
  output logic                    axiARReady,
  input  logic [AxiIdWidth-1:0]   axiARId,
  input  logic [63:0]             axiARAddr,
  input  logic [7:0]              axiARLen,
  input  logic [2:0]              axiARSize,
  input  logic [3:0]              axiARCache,
  output logic                    axiRValid,
  input  logic                    axiRReady,
  output logic [AxiIdWidth-1:0]   axiRId,
  output logic [DataWidth-1:0]    axiRData,
  output logic [1:0]              axiRResp,
  output logic                    axiRLast,
  output logic                    memRdEn,
  output logic [MemAddrWidth-1:0] memRdAddr,
  input  logic [DataWidth-1:0]    memRdData
);
  localparam int AddrHi    = DataIndexSize + MemAddrWidth;
  localparam int FifoDepth = 1 << ArFifoIndexSize;
  localparam logic [1:0] RespOkay = 2'b00;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [63:0]           addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } ar_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
    logic                  last;
    logic [DataWidth-1:0]  data;
  } beat_t;

  typedef enum logic {Idle, Burst} state_t;

  // ---------------- AR FIFO (extra pointer bit separates full from empty)
  ar_t                      fifo_mem [FifoDepth];
  logic [ArFifoIndexSize:0] fifo_wr, fifo_rd;
  logic                     fifo_empty, fifo_full, ar_push, ar_pop, ready_en;
  ar_t                      head;
  logic [1:0]               head_resp;

  assign fifo_empty = (fifo_wr == fifo_rd);
  assign fifo_full  = (fifo_wr[ArFifoIndexSize] != fifo_rd[ArFifoIndexSize]) &&
                      (fifo_wr[ArFifoIndexSize-1:0] == fifo_rd[ArFifoIndexSize-1:0]);
  // ready_en keeps axiARReady low until the first edge after reset release
  assign axiARReady = ready_en & ~fifo_full;
  assign ar_push    = axiARValid & axiARReady;
  assign head       = fifo_mem[fifo_rd[ArFifoIndexSize-1:0]];

  always_ff @(posedge clk or posedge axiReset) begin
    if (axiReset) begin
      ready_en <= 1'b0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (ar_push) fifo_wr <= fifo_wr + 1'b1;
      if (ar_pop)  fifo_rd <= fifo_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_push)
      fifo_mem[fifo_wr[ArFifoIndexSize-1:0]] <= '{id: axiARId, addr: axiARAddr,
                                                 len: axiARLen, size: axiARSize};
  end

`ifdef AXI_READ_RESP_ERR_CHECK_EN
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  always_comb begin
    head_resp = RespOkay;
    if (|head.addr[63:AddrHi])                head_resp = RespDecErr;
    else if (head.size != 3'(DataIndexSize))  head_resp = RespSlvErr;
  end
`else
  assign head_resp = RespOkay;
`endif

  // byte offset, cache hints and (in the default build) size/high address
  // bits carry no meaning for this target
  logic unused_ok;
  assign unused_ok = ^{axiARCache, head.size, head.addr[63:AddrHi],
                       head.addr[DataIndexSize-1:0]};

  // ---------------- Skid buffer / credit
  beat_t      skid_mem [2];
  logic       skid_wr, skid_rd;
  logic [1:0] skid_cnt;
  logic       r_pop, credit_ok;
  logic [2:0] occ_next;

  logic                  tag_vld, tag_last;
  logic [AxiIdWidth-1:0] tag_id;
  logic [1:0]            tag_resp;

  assign r_pop = axiRValid & axiRReady;
  // occupancy next cycle before a new issue; issuing must keep the total <= 2
  assign occ_next  = {1'b0, skid_cnt} + {2'b0, tag_vld} - {2'b0, r_pop};
  assign credit_ok = (occ_next <= 3'd1);

  // ---------------- Burst engine
  state_t                  state_q, state_d;
  logic [MemAddrWidth-1:0] word_addr;
  logic [7:0]              beats_left;
  logic [AxiIdWidth-1:0]   burst_id;
  logic [1:0]              burst_resp;
  logic                    issue, load;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    load    = 1'b0;
    case (state_q)
      Idle: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = Burst;
        end
      end
      Burst: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (beats_left == 8'd0) begin
            if (!fifo_empty) load    = 1'b1;  // chain next burst, no bubble
            else             state_d = Idle;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  assign ar_pop    = load;
  assign memRdEn   = issue && (burst_resp == RespOkay);
  assign memRdAddr = word_addr;

  always_ff @(posedge clk or posedge axiReset) begin
    if (axiReset) begin
      state_q    <= Idle;
      word_addr  <= '0;
      beats_left <= '0;
      burst_id   <= '0;
      burst_resp <= RespOkay;
      tag_vld    <= 1'b0;
      tag_last   <= 1'b0;
      tag_id     <= '0;
      tag_resp   <= RespOkay;
    end else begin
      state_q <= state_d;
      if (load) begin
        word_addr  <= head.addr[AddrHi-1:DataIndexSize];
        beats_left <= head.len;
        burst_id   <= head.id;
        burst_resp <= head_resp;
      end else if (issue) begin
        word_addr  <= word_addr + 1'b1;
        beats_left <= beats_left - 1'b1;
      end
      // tag stage lines up with memRdData one cycle after the RAM strobe
      tag_vld  <= issue;
      tag_last <= (beats_left == 8'd0);
      tag_id   <= burst_id;
      tag_resp <= burst_resp;
    end
  end

  always_ff @(posedge clk or posedge axiReset) begin
    if (axiReset) begin
      skid_wr     <= 1'b0;
      skid_rd     <= 1'b0;
      skid_cnt    <= '0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
    end else begin
      if (tag_vld) begin
        skid_mem[skid_wr] <= '{id: tag_id, resp: tag_resp, last: tag_last,
                               data: (tag_resp == RespOkay) ? memRdData : '0};
        skid_wr <= ~skid_wr;
      end
      if (r_pop) skid_rd <= ~skid_rd;
      skid_cnt <= skid_cnt + {1'b0, tag_vld} - {1'b0, r_pop};
    end
  end

  // head entry is only replaced on a pop, so R holds steady while stalled
  assign axiRValid = (skid_cnt != 2'd0);
  assign axiRId    = skid_mem[skid_rd].id;
  assign axiRData  = skid_mem[skid_rd].data;
  assign axiRResp  = skid_mem[skid_rd].resp;
  assign axiRLast  = skid_mem[skid_rd].last;

endmodule
